// File: rtl/grid_driver.sv
// Grid solver initiator: go edge -> one start pulse, wait for done/timeout, latch result (optional reseed-retry via SUDOKU_DRIVER_RETRY_EN).
// Latency: start pulse one cycle after the go edge; result_valid one cycle after done is sampled (done ignored in first WAIT cycle).
// Backpressure: none; go edges while busy are dropped, abort returns to IDLE on the next cycle.
module grid_driver #(
    parameter int unsigned       SEED_W      = 8,
    parameter int unsigned       CNT_W       = 24,
    parameter int unsigned       TIMEOUT     = 24'hFF_FFFF,
    parameter int unsigned       MAX_TRIES   = 4,
    parameter logic [SEED_W-1:0] SEED_STRIDE = 8'd37
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [SEED_W-1:0] seed_in,
    input  logic              abort,
    output logic              grid_start,
    output logic [SEED_W-1:0] grid_seed,
    input  logic              grid_done,
    input  logic              grid_success,
    output logic              busy,
    output logic              result_valid,
    output logic              result_success,
    output logic              result_timeout,
    output logic [2:0]        tries,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESEED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       TRY_CAP  = 3'(MAX_TRIES);
`ifdef SUDOKU_DRIVER_RETRY_EN
    localparam logic             RETRY_ON = 1'b1;
`else
    localparam logic             RETRY_ON = 1'b0;
`endif

    state_t state, next_state;
    logic   go_q;
    logic   go_edge;
    logic   first_wait;
    logic   retry_ok;
    logic   fresh;
    logic   set_success;
    logic   set_timeout;
    logic   do_abort;

    assign go_edge      = go & ~go_q;
    assign busy         = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_RESEED);
    assign result_valid = (state == S_DONE);
    // cycles is cleared in LAUNCH, so zero marks the first WAIT cycle
    assign first_wait   = (cycles == '0);
    assign retry_ok     = RETRY_ON && (tries < TRY_CAP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        fresh       = 1'b0;
        set_success = 1'b0;
        set_timeout = 1'b0;
        do_abort    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (go_edge) begin
                    next_state = S_LAUNCH;
                    fresh      = 1'b1;
                end
            end
            S_LAUNCH: next_state = S_WAIT;
            S_WAIT: begin
                if (!first_wait) begin
                    if (grid_done) begin
                        if (grid_success) begin
                            next_state  = S_DONE;
                            set_success = 1'b1;
                        end else if (retry_ok) begin
                            next_state = S_RESEED;
                        end else begin
                            next_state = S_DONE;
                        end
                    end else if (cycles == CYC_LAST) begin
                        next_state  = S_DONE;
                        set_timeout = 1'b1;
                    end
                end
            end
            S_RESEED: next_state = S_LAUNCH;
            default:  next_state = S_IDLE;
        endcase
        // abort overrides whatever the run decided this cycle
        if (abort && busy) begin
            next_state  = S_IDLE;
            set_success = 1'b0;
            set_timeout = 1'b0;
            do_abort    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            go_q           <= 1'b0;
            grid_start     <= 1'b0;
            grid_seed      <= '0;
            result_success <= 1'b0;
            result_timeout <= 1'b0;
            tries          <= 3'd0;
            cycles         <= '0;
        end else begin
            go_q       <= go;
            grid_start <= (next_state == S_LAUNCH);
            if (fresh) begin
                grid_seed      <= seed_in;
                tries          <= 3'd0;
                result_success <= 1'b0;
                result_timeout <= 1'b0;
            end
            if (state == S_LAUNCH && !do_abort) begin
                tries  <= tries + 3'd1;
                cycles <= '0;
            end
            if (state == S_WAIT && !do_abort && !(&cycles)) begin
                cycles <= cycles + 1'b1;
            end
            if (state == S_RESEED && !do_abort) begin
                grid_seed <= grid_seed + SEED_STRIDE;
            end
            if (set_success) begin
                result_success <= 1'b1;
            end
            if (set_timeout) begin
                result_timeout <= 1'b1;
            end
        end
    end

endmodule
